// File: rtl/fifo_pkg.sv
// ============================================================================
//  fifo_pkg : shared widths and types for the FIFO and its read-side stream.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BURST_LEN  = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [1:0]            buf_occ_t;

    localparam buf_occ_t OCC_EMPTY = 2'd0;
    localparam buf_occ_t OCC_ONE   = 2'd1;
    localparam buf_occ_t OCC_FULL  = 2'd2;

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_out_buf.sv
// ============================================================================
//  fifo_out_buf : 2-entry order-preserving buffer; head entry drives rd_data.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module fifo_out_buf #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output fifo_pkg::buf_occ_t     occ
);

    import fifo_pkg::*;

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    buf_occ_t              occ_q, occ_d;
    logic                  rd_ok;
    logic                  wr_ok;

    // A write into a full buffer is only accepted when the head leaves in the same cycle.
    assign rd_ok = rd_en && (occ_q != OCC_EMPTY);
    assign wr_ok = wr_en && ((occ_q != OCC_FULL) || rd_ok);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({wr_ok, rd_ok})
            2'b10: begin
                if (occ_q == OCC_EMPTY) begin
                    head_d = wr_data;
                end else begin
                    tail_d = wr_data;
                end
                occ_d = occ_q + OCC_ONE;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_ONE;
            end
            2'b11: begin
                if (occ_q == OCC_FULL) begin
                    head_d = tail_q;
                    tail_d = wr_data;
                end else begin
                    head_d = wr_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign rd_data = head_q;
    assign occ     = occ_q;

endmodule : fifo_out_buf

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
//  fifo_rd_stream : pops the FIFO read port and presents a valid/ready stream
//                   grouped into fixed-length bursts marked by m_last.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = fifo_pkg::BURST_LEN,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          fifo_empty,
    output logic                          fifo_pop,
    input  logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [$clog2(BURST_LEN)-1:0]  beat_idx,
    output logic [CNT_WIDTH-1:0]          words_out
);

    import fifo_pkg::*;

    localparam int                BEAT_W    = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic                  inflight_q;
    buf_occ_t              occ;
    logic                  xfer;
    logic [2:0]            pending;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;

    assign m_valid = (occ != OCC_EMPTY);
    assign xfer    = m_valid && m_ready;

    // Credits: buffered words plus the word still coming back from the FIFO must
    // leave room for this pop, counting the slot freed by a transfer this cycle.
    assign pending  = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_pop = rst && en && !fifo_empty && (pending < (xfer ? 3'd3 : 3'd2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_pop;
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (fifo_data),
        .rd_en   (xfer),
        .rd_data (m_data),
        .occ     (occ)
    );

    always_comb begin
        beat_d  = beat_q;
        words_d = words_q;
        if (xfer) begin
            beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
            words_d = words_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q  <= '0;
            words_q <= '0;
        end else begin
            beat_q  <= beat_d;
            words_q <= words_d;
        end
    end

    assign m_last    = m_valid && (beat_q == LAST_BEAT);
    assign beat_idx  = beat_q;
    assign words_out = words_q;

endmodule : fifo_rd_stream

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
//  tb_fifo_rd_stream : self-checking bench for fifo_rd_stream with a queue FIFO.
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [7:0]  fifo_data = 8'h00;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;
    logic [1:0]  beat_idx;
    logic [15:0] words_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] pushed[$];
    int occ_m, infl_m, n_acc;

    logic        a_pop, a_valid, a_last;
    logic [7:0]  a_data;
    logic [1:0]  a_beat;
    logic [15:0] a_words;
    logic        e_pop, e_valid, e_last, e_xfer;
    logic [7:0]  e_data;
    logic [1:0]  e_beat;
    logic [15:0] e_words;

    fifo_rd_stream dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .beat_idx   (beat_idx),
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    task automatic reset_model();
        fifo_q.delete();
        pushed.delete();
        occ_m  = 0;
        infl_m = 0;
        n_acc  = 0;
        fifo_empty = 1'b1;
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        pushed.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Samples the DUT, derives this cycle's expectations from the word ledger, then
    // advances one clock; returns at the following negedge with inputs free to change.
    task automatic tick();
        logic [7:0] nd;
        #1;
        a_pop = fifo_pop; a_valid = m_valid; a_data = m_data;
        a_last = m_last; a_beat = beat_idx; a_words = words_out;
        e_valid = (occ_m != 0);
        e_xfer  = e_valid && m_ready;
        e_pop   = en && (fifo_q.size() != 0) && ((occ_m + infl_m - (e_xfer ? 1 : 0)) < 2);
        e_data  = (n_acc < pushed.size()) ? pushed[n_acc] : 8'h00;
        e_beat  = 2'(n_acc % BL);
        e_last  = e_valid && ((n_acc % BL) == BL - 1);
        e_words = 16'(n_acc);
        @(posedge clk);
        if (e_xfer) begin
            occ_m--;
            n_acc++;
        end
        if (infl_m != 0) occ_m++;
        infl_m = e_pop ? 1 : 0;
        if (a_pop && fifo_q.size() != 0) nd = fifo_q.pop_front();
        else nd = 8'($urandom);
        #1;
        fifo_data  = nd;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; m_ready = 1'b1; fifo_empty = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({fifo_pop, m_valid, m_last, beat_idx, words_out, m_data} !== 29'd0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got pop=%b valid=%b last=%b beat=%0d words=%0d data=%0h required all zero",
                         k, fifo_pop, m_valid, m_last, beat_idx, words_out, m_data);
            end
        end
        reset_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        int first_pop, first_val, first_x, last_x, nx;
        logic [7:0] lasts[$];
        first_pop = -1; first_val = -1; first_x = -1; last_x = -1; nx = 0;
        en = 1'b1; m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (a_pop !== e_pop) begin errors++; $display("FAIL stream_pop k=%0d got=%b exp=%b", k, a_pop, e_pop); end
            checks++; if (a_valid !== e_valid) begin errors++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, a_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if ({a_data, a_last, a_beat} !== {e_data, e_last, e_beat}) begin
                    errors++;
                    $display("FAIL stream_word k=%0d got data=%0h last=%b beat=%0d exp data=%0h last=%b beat=%0d",
                             k, a_data, a_last, a_beat, e_data, e_last, e_beat);
                end
            end
            checks++; if (a_words !== e_words) begin errors++; $display("FAIL stream_words k=%0d got=%0d exp=%0d", k, a_words, e_words); end
            if (a_pop && first_pop < 0) first_pop = k;
            if (a_valid && first_val < 0) first_val = k;
            if (a_valid && m_ready) begin
                if (first_x < 0) first_x = k;
                last_x = k;
                nx++;
                if (a_last) lasts.push_back(a_data);
            end
        end
        checks++; if (first_val - first_pop != 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", first_val - first_pop); end
        checks++; if (nx != 8 || last_x - first_x != 7) begin errors++; $display("FAIL stream_b2b got words=%0d span=%0d exp words=8 span=7", nx, last_x - first_x); end
        checks++;
        if (lasts.size() != 2 || lasts[0] !== 8'h04 || lasts[1] !== 8'h08) begin
            errors++; $display("FAIL stream_last got count=%0d exp last on 04 and 08", lasts.size());
        end
        #1;
        checks++; if (words_out !== 16'd8) begin errors++; $display("FAIL stream_total got=%0d exp=8", words_out); end
    endtask

    task automatic test_empty_midburst();
        int nx;
        logic [1:0] beat3;
        logic [3:0] last_mask;
        nx = 0; beat3 = 2'd3; last_mask = 4'h0;
        en = 1'b1; m_ready = 1'b1;
        push(8'($urandom)); push(8'($urandom));
        for (int k = 0; k < 20; k++) begin
            if (k == 9) begin
                push(8'($urandom)); push(8'($urandom));
            end
            tick();
            checks++; if (a_pop !== e_pop) begin errors++; $display("FAIL gap_pop k=%0d got=%b exp=%b", k, a_pop, e_pop); end
            checks++; if (a_valid !== e_valid) begin errors++; $display("FAIL gap_valid k=%0d got=%b exp=%b", k, a_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if ({a_data, a_last, a_beat} !== {e_data, e_last, e_beat}) begin
                    errors++;
                    $display("FAIL gap_word k=%0d got data=%0h last=%b beat=%0d exp data=%0h last=%b beat=%0d",
                             k, a_data, a_last, a_beat, e_data, e_last, e_beat);
                end
            end
            if (a_valid && m_ready && nx < 4) begin
                if (nx == 2) beat3 = a_beat;
                last_mask[nx] = a_last;
                nx++;
            end
        end
        checks++; if (beat3 !== 2'd2) begin errors++; $display("FAIL gap_beat3 got=%0d exp=2", beat3); end
        checks++; if (nx != 4 || last_mask !== 4'b1000) begin errors++; $display("FAIL gap_last got count=%0d mask=%b exp count=4 mask=1000", nx, last_mask); end
    endtask

    task automatic test_backpressure();
        int nx, base;
        logic held_pop;
        nx = 0; base = n_acc; held_pop = 1'b0;
        en = 1'b1; m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) push(8'(i));
        for (int k = 0; k < 10 && nx == 0; k++) begin
            tick();
            if (a_valid && m_ready) nx++;
        end
        checks++; if (nx != 1) begin errors++; $display("FAIL bp_first got=%0d exp=1", nx); end
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (a_pop !== e_pop) begin errors++; $display("FAIL bp_pop k=%0d got=%b exp=%b", k, a_pop, e_pop); end
            checks++; if (a_valid !== e_valid || (e_valid && a_data !== e_data)) begin
                errors++; $display("FAIL bp_hold k=%0d got valid=%b data=%0h exp valid=%b data=%0h", k, a_valid, a_data, e_valid, e_data);
            end
            held_pop = held_pop | a_pop;
        end
        checks++; if (held_pop !== 1'b0 || a_data !== 8'h02) begin errors++; $display("FAIL bp_stall got pop=%b data=%0h exp pop=0 data=02", held_pop, a_data); end
        m_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (a_pop !== e_pop) begin errors++; $display("FAIL bp_resume_pop k=%0d got=%b exp=%b", k, a_pop, e_pop); end
            if (e_valid) begin
                checks++;
                if ({a_valid, a_data, a_last, a_beat} !== {1'b1, e_data, e_last, e_beat}) begin
                    errors++;
                    $display("FAIL bp_resume_word k=%0d got valid=%b data=%0h beat=%0d exp data=%0h beat=%0d", k, a_valid, a_data, a_beat, e_data, e_beat);
                end
            end
        end
        #1;
        checks++; if (words_out !== 16'(base + 6)) begin errors++; $display("FAIL bp_total got=%0d exp=%0d", words_out, base + 6); end
    endtask

    task automatic test_enable();
        int base, pops;
        logic saw;
        base = n_acc; pops = 0; saw = 1'b0;
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        for (int k = 0; k < 5 && !saw; k++) begin
            tick();
            saw = a_pop;
        end
        checks++; if (!saw) begin errors++; $display("FAIL en_first_pop got=0 exp=1"); end
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (a_valid !== e_valid || (e_valid && a_data !== e_data)) begin
                errors++; $display("FAIL en_drain k=%0d got valid=%b data=%0h exp valid=%b data=%0h", k, a_valid, a_data, e_valid, e_data);
            end
            if (a_pop) pops++;
        end
        checks++; if (pops != 0 || n_acc - base != 1) begin errors++; $display("FAIL en_off got pops=%0d delivered=%0d exp pops=0 delivered=1", pops, n_acc - base); end
        en = 1'b1;
        tick();
        checks++; if (a_pop !== 1'b1) begin errors++; $display("FAIL en_resume got=%b exp=1", a_pop); end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (e_valid) begin
                checks++;
                if ({a_valid, a_data, a_beat} !== {1'b1, e_data, e_beat}) begin
                    errors++; $display("FAIL en_rest k=%0d got data=%0h beat=%0d exp data=%0h beat=%0d", k, a_data, a_beat, e_data, e_beat);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 340; k++) begin
            if (k < 300) begin
                en      = ($urandom % 4) != 0;
                m_ready = ($urandom % 3) != 0;
                if (($urandom % 2) == 0 && fifo_q.size() < 12) push(8'($urandom));
            end else begin
                en = 1'b1; m_ready = 1'b1;
            end
            tick();
            checks++; if (a_pop !== e_pop) begin errors++; $display("FAIL rand_pop k=%0d got=%b exp=%b", k, a_pop, e_pop); end
            checks++; if (a_valid !== e_valid) begin errors++; $display("FAIL rand_valid k=%0d got=%b exp=%b", k, a_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if ({a_data, a_last, a_beat} !== {e_data, e_last, e_beat}) begin
                    errors++;
                    $display("FAIL rand_word k=%0d got data=%0h last=%b beat=%0d exp data=%0h last=%b beat=%0d",
                             k, a_data, a_last, a_beat, e_data, e_last, e_beat);
                end
            end
            checks++; if (a_words !== e_words) begin errors++; $display("FAIL rand_words k=%0d got=%0d exp=%0d", k, a_words, e_words); end
        end
    endtask

    task automatic test_reset_midburst();
        int nx;
        logic got_first;
        nx = 0; got_first = 1'b0;
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        for (int k = 0; k < 12 && nx < 2; k++) begin
            tick();
            if (a_valid && m_ready) nx++;
        end
        checks++; if (nx != 2) begin errors++; $display("FAIL rmb_pre got=%0d exp=2", nx); end
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_pop, m_valid, m_last, beat_idx, words_out, m_data} !== 29'd0) begin
            errors++;
            $display("FAIL rmb_async got pop=%b valid=%b beat=%0d words=%0d data=%0h required all zero",
                     fifo_pop, m_valid, beat_idx, words_out, m_data);
        end
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (a_valid !== e_valid) begin errors++; $display("FAIL rmb_valid k=%0d got=%b exp=%b", k, a_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if ({a_data, a_last, a_beat, a_words} !== {e_data, e_last, e_beat, e_words}) begin
                    errors++;
                    $display("FAIL rmb_word k=%0d got data=%0h beat=%0d words=%0d exp data=%0h beat=%0d words=%0d",
                             k, a_data, a_beat, a_words, e_data, e_beat, e_words);
                end
            end
            if (a_valid && m_ready && !got_first) begin
                got_first = 1'b1;
                checks++;
                if (a_beat !== 2'd0 || a_words !== 16'd0) begin
                    errors++; $display("FAIL rmb_first got beat=%0d words=%0d exp beat=0 words=0", a_beat, a_words);
                end
            end
        end
        checks++; if (!got_first) begin errors++; $display("FAIL rmb_no_word got=0 exp=1"); end
    endtask

    initial begin
        reset_model();
        test_reset();
        test_streaming();
        test_empty_midburst();
        test_backpressure();
        test_enable();
        test_random();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_rd_stream

`default_nettype wire
